// File: rtl/fcn_pkg.sv
// Shared types for the BRAM data mover and the BRAM stream loader.
//   loader_state_t : IDLE / WRITE / DONE control states
//   bram_target_t  : destination BRAM select (input or weight)
package fcn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } loader_state_t;

  typedef enum logic {
    TGT_INPUT  = 1'b0,
    TGT_WEIGHT = 1'b1
  } bram_target_t;

endpackage

// File: rtl/bram_stream_loader_if.sv
// Valid/ready word stream from the host side into the loader.
//   s_valid : word valid (host -> loader)
//   s_ready : loader can accept a word (loader -> host)
//   s_data  : stream word (host -> loader)
// Modports: master = host side, slave = loader side.
interface bram_stream_loader_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/bram_stream_loader.sv
// Stream-to-BRAM loader: writes i_num_cnt consecutive stream words, starting
// at i_base_addr (wrapping at MEM_SIZE), into the input or weight BRAM.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   i_run/i_target/i_base_addr/i_num_cnt : start pulse and transfer setup
//   o_idle/o_write/o_done      : status (o_done is a one-cycle pulse)
//   s (slave modport)          : valid/ready word stream
//   ce/we/addr/din_{input,weight} : BRAM write ports
//   o_checksum                 : sum of accepted words (only with LOADER_CHECKSUM_EN)
// Optional feature macro: LOADER_CHECKSUM_EN
module bram_stream_loader
  import fcn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MEM_SIZE   = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run,
  input  logic                  i_target,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_num_cnt,
  output logic                  o_idle,
  output logic                  o_write,
  output logic                  o_done,
  bram_stream_loader_if.slave   s,
  output logic                  ce_input,
  output logic                  we_input,
  output logic [ADDR_WIDTH-1:0] addr_input,
  output logic [DATA_WIDTH-1:0] din_input,
  output logic                  ce_weight,
  output logic                  we_weight,
  output logic [ADDR_WIDTH-1:0] addr_weight,
  output logic [DATA_WIDTH-1:0] din_weight
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] o_checksum
`endif
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;

  loader_state_t state_q, state_d;
  bram_target_t  target_q, target_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] num_q, num_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          ce_in_q, ce_in_d, ce_wt_q, ce_wt_d;
  logic          done_q, done_d, idle_q, idle_d, write_q, write_d;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
`endif

  // s_ready follows the state directly so a word can be taken every cycle.
  assign s.s_ready = (state_q == WRITE);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    base_d   = base_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    din_d    = din_q;
    ce_in_d  = 1'b0;
    ce_wt_d  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_run) begin
          target_d = bram_target_t'(i_target);
          base_d   = i_base_addr;
          num_d    = i_num_cnt;
          cnt_d    = '0;
`ifdef LOADER_CHECKSUM_EN
          sum_d    = '0;
`endif
          state_d  = (i_num_cnt == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        if (s.s_valid) begin
          // MEM_SIZE is a power of two, so the modulo is a plain wrap.
          addr_d = AW'((32'(base_q) + 32'(cnt_q)) % 32'(MEM_SIZE));
          din_d  = s.s_data;
          if (target_q == TGT_WEIGHT) ce_wt_d = 1'b1;
          else                        ce_in_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum_d  = DW'(sum_q + s.s_data);
`endif
          if (cnt_q == AW'(num_q - AW'(1))) state_d = DONE;
          else                              cnt_d   = AW'(cnt_q + AW'(1));
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d  = (state_d == DONE);
    idle_d  = (state_d == IDLE);
    write_d = (state_d == WRITE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= TGT_INPUT;
      base_q   <= '0;
      num_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      ce_in_q  <= 1'b0;
      ce_wt_q  <= 1'b0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
      write_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      base_q   <= base_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      ce_in_q  <= ce_in_d;
      ce_wt_q  <= ce_wt_d;
      done_q   <= done_d;
      idle_q   <= idle_d;
      write_q  <= write_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  // Writes are single-word strobes, so ce and we coincide.
  assign ce_input    = ce_in_q;
  assign we_input    = ce_in_q;
  assign ce_weight   = ce_wt_q;
  assign we_weight   = ce_wt_q;
  assign addr_input  = addr_q;
  assign addr_weight = addr_q;
  assign din_input   = din_q;
  assign din_weight  = din_q;
  assign o_done      = done_q;
  assign o_idle      = idle_q;
  assign o_write     = write_q;
`ifdef LOADER_CHECKSUM_EN
  assign o_checksum  = sum_q;
`endif

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader: a transfer-level model predicts
// every registered output per cycle; BRAM contents are captured from strobes
// and compared against the model memory and hand-computed literals.
module tb_bram_stream_loader;

  logic        clk;
  logic        reset;
  logic        i_run;
  logic        i_target;
  logic [11:0] i_base_addr;
  logic [11:0] i_num_cnt;
  logic        o_idle, o_write, o_done;
  logic        ce_input, we_input, ce_weight, we_weight;
  logic [11:0] addr_input, addr_weight;
  logic [31:0] din_input, din_weight;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] o_checksum;
`endif

  bram_stream_loader_if #(.DATA_WIDTH(32)) sif ();

  bram_stream_loader #(
    .DATA_WIDTH(32), .ADDR_WIDTH(12), .MEM_SIZE(4096)
  ) dut (
    .clk(clk), .reset(reset), .i_run(i_run), .i_target(i_target),
    .i_base_addr(i_base_addr), .i_num_cnt(i_num_cnt),
    .o_idle(o_idle), .o_write(o_write), .o_done(o_done),
    .s(sif),
    .ce_input(ce_input), .we_input(we_input), .addr_input(addr_input), .din_input(din_input),
    .ce_weight(ce_weight), .we_weight(we_weight), .addr_weight(addr_weight), .din_weight(din_weight)
`ifdef LOADER_CHECKSUM_EN
    , .o_checksum(o_checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the expected outputs for the cycle after the next edge.
  bit          chk_en = 1'b0;
  bit          exp_idle, exp_write, exp_done, exp_ready;
  bit          exp_ce_in, exp_ce_wt;
  logic [11:0] exp_addr;
  logic [31:0] exp_din, exp_sum;
  bit          m_active = 1'b0;
  bit          m_tgt;
  int          m_base, m_cnt, m_k;
  bit   [31:0] mdl_in [4096];
  bit   [31:0] mdl_wt [4096];

  // Contents captured from DUT strobes, plus event counters.
  bit   [31:0] cap_in [4096];
  bit   [31:0] cap_wt [4096];
  int          n_we_in = 0, n_we_wt = 0, n_done = 0, n_ready = 0;
  logic [11:0] last_done_addr = '0;
  bit          last_done_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare, sampled shortly after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("o_idle", 32'(o_idle), 32'(exp_idle));
      chk("o_write", 32'(o_write), 32'(exp_write));
      chk("o_done", 32'(o_done), 32'(exp_done));
      chk("s_ready", 32'(sif.s_ready), 32'(exp_ready));
      chk("ce_input", 32'(ce_input), 32'(exp_ce_in));
      chk("we_input", 32'(we_input), 32'(exp_ce_in));
      chk("ce_weight", 32'(ce_weight), 32'(exp_ce_wt));
      chk("we_weight", 32'(we_weight), 32'(exp_ce_wt));
      if (exp_ce_in) begin
        chk("addr_input", 32'(addr_input), 32'(exp_addr));
        chk("din_input", din_input, exp_din);
      end
      if (exp_ce_wt) begin
        chk("addr_weight", 32'(addr_weight), 32'(exp_addr));
        chk("din_weight", din_weight, exp_din);
      end
`ifdef LOADER_CHECKSUM_EN
      if (exp_done) chk("o_checksum", o_checksum, exp_sum);
`endif
      if (ce_input && we_input)   begin cap_in[addr_input]  = din_input;  n_we_in++; end
      if (ce_weight && we_weight) begin cap_wt[addr_weight] = din_weight; n_we_wt++; end
      if (sif.s_ready) n_ready++;
      if (o_done) begin
        n_done++;
        last_done_addr = we_input ? addr_input : addr_weight;
        last_done_we   = we_input | we_weight;
      end
    end
  end

  // Drive one cycle of inputs and advance the model across the next edge.
  task automatic cyc(input bit rst, input bit run, input bit tgt, input int base,
                     input int cnt, input bit valid, input logic [31:0] data);
    bit cur_idle;
    int a;
    reset = rst; i_run = run; i_target = tgt;
    i_base_addr = 12'(base); i_num_cnt = 12'(cnt);
    sif.s_valid = valid; sif.s_data = data;
    cur_idle  = !m_active && !exp_done;
    exp_ce_in = 1'b0; exp_ce_wt = 1'b0; exp_done = 1'b0;
    if (rst) begin
      m_active = 1'b0; exp_addr = '0; exp_din = '0; exp_sum = '0;
    end else if (m_active && valid) begin
      a = (m_base + m_k) % 4096;
      exp_addr = 12'(a); exp_din = data; exp_sum = exp_sum + data;
      if (m_tgt) begin exp_ce_wt = 1'b1; mdl_wt[a] = data; end
      else       begin exp_ce_in = 1'b1; mdl_in[a] = data; end
      m_k++;
      if (m_k == m_cnt) begin m_active = 1'b0; exp_done = 1'b1; end
    end else if (cur_idle && run) begin
      m_tgt = tgt; m_base = base; m_cnt = cnt; m_k = 0; exp_sum = '0;
      if (cnt == 0) exp_done = 1'b1;
      else          m_active = 1'b1;
    end
    exp_write = m_active; exp_ready = m_active;
    exp_idle  = !m_active && !exp_done;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
  endtask

  function automatic int mem_mismatches();
    int bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (cap_in[i] != mdl_in[i]) bad++;
      if (cap_wt[i] != mdl_wt[i]) bad++;
    end
    return bad;
  endfunction

  initial begin
    int s_in, s_wt, s_dn, s_rd;
    bit [31:0] w4 [4];
    bit [31:0] vpat;
    int budget;

    reset = 1'b1; i_run = 1'b0; i_target = 1'b0; i_base_addr = '0; i_num_cnt = '0;
    sif.s_valid = 1'b0; sif.s_data = '0;
    exp_idle = 1'b1; exp_write = 1'b0; exp_done = 1'b0; exp_ready = 1'b0;
    exp_ce_in = 1'b0; exp_ce_wt = 1'b0; exp_addr = '0; exp_din = '0; exp_sum = '0;
    chk_en = 1'b1;
    @(negedge clk);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
    idle_cycles(2);

    // Input BRAM, base 0, four back-to-back words.
    s_we_snapshot: begin s_in = n_we_in; s_wt = n_we_wt; s_dn = n_done; end
    cyc(1'b0, 1'b1, 1'b0, 0, 4, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h11);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h22);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h33);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h44);
    idle_cycles(3);
    chk("t1_mem0", cap_in[0], 32'h11);
    chk("t1_mem1", cap_in[1], 32'h22);
    chk("t1_mem2", cap_in[2], 32'h33);
    chk("t1_mem3", cap_in[3], 32'h44);
    chk("t1_we_input_count", 32'(n_we_in - s_in), 32'd4);
    chk("t1_we_weight_count", 32'(n_we_wt - s_wt), 32'd0);
    chk("t1_done_count", 32'(n_done - s_dn), 32'd1);
    chk("t1_done_addr", 32'(last_done_addr), 32'd3);
    chk("t1_done_with_strobe", 32'(last_done_we), 32'd1);

    // Weight BRAM, wrap from 4094.
    w4[0] = 32'hA1A1_0001; w4[1] = 32'hB2B2_0002; w4[2] = 32'hC3C3_0003; w4[3] = 32'hD4D4_0004;
    cyc(1'b0, 1'b1, 1'b1, 4094, 4, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, w4[i]);
    idle_cycles(2);
    chk("t2_wt4094", cap_wt[4094], 32'hA1A1_0001);
    chk("t2_wt4095", cap_wt[4095], 32'hB2B2_0002);
    chk("t2_wt0", cap_wt[0], 32'hC3C3_0003);
    chk("t2_wt1", cap_wt[1], 32'hD4D4_0004);

    // Gapped stream: valid 1,0,0,1,0,1.
    s_in = n_we_in;
    cyc(1'b0, 1'b1, 1'b0, 100, 3, 1'b0, 32'h0);
    vpat = 32'b101001;
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, vpat[i], 32'h500 + 32'(i));
    idle_cycles(2);
    chk("t3_strobe_count", 32'(n_we_in - s_in), 32'd3);
    chk("t3_mem102", cap_in[102], 32'h505);

    // Zero-length transfer.
    s_in = n_we_in; s_wt = n_we_wt; s_dn = n_done; s_rd = n_ready;
    cyc(1'b0, 1'b1, 1'b0, 7, 0, 1'b1, 32'hDEAD);
    idle_cycles(3);
    chk("t4_done_count", 32'(n_done - s_dn), 32'd1);
    chk("t4_ready_count", 32'(n_ready - s_rd), 32'd0);
    chk("t4_strobes", 32'(n_we_in - s_in + n_we_wt - s_wt), 32'd0);

    // Reset after two of eight words, then a short clean transfer.
    s_wt = n_we_wt;
    cyc(1'b0, 1'b1, 1'b1, 200, 8, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h7001);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h7002);
    cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 32'h7003);
    chk("t5_idle_after_reset", 32'(o_idle), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h7100);
    chk("t5_strobes", 32'(n_we_wt - s_wt), 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 300, 2, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h8001);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h8002);
    idle_cycles(2);
    chk("t5_mem300", cap_in[300], 32'h8001);
    chk("t5_mem301", cap_in[301], 32'h8002);

`ifdef LOADER_CHECKSUM_EN
    cyc(1'b0, 1'b1, 1'b0, 50, 2, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'hFFFF_FFFF);
    cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 32'h0000_0002);
    chk("t6_checksum", o_checksum, 32'h0000_0001);
    idle_cycles(2);
    chk("t6_checksum_held", o_checksum, 32'h0000_0001);
`endif

    // Randomised transfers with stray i_run pulses during the transfer.
    for (int t = 0; t < 30; t++) begin
      cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
          int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), $urandom);
      budget = 0;
      while ((m_active || exp_done) && budget < 200) begin
        cyc(1'b0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 12)),
            ($urandom_range(0, 9) < 7), $urandom);
        budget++;
      end
      if (budget >= 200) chk("rand_timeout", 32'(budget), 32'd0);
      idle_cycles(1);
      chk("rand_mem", 32'(mem_mismatches()), 32'd0);
    end

    idle_cycles(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
